// File: rtl/key_turn_conditioner_pkg.sv
// Shared constants for the key turn conditioner.
//   turn_e        : request FSM encoding (bit0 = right pending, bit1 = left pending)
//   DEBOUNCE_BITS_DEF : default debounce counter width (2^18 cycles ~ 10.5 ms @ 25 MHz)
//   KEY_RIGHT/KEY_LEFT : lane indices into the per-key vectors
package key_turn_conditioner_pkg;
  localparam int DEBOUNCE_BITS_DEF = 18;
  localparam int NUM_KEYS          = 2;
  localparam int KEY_RIGHT         = 0;
  localparam int KEY_LEFT          = 1;

  typedef enum logic [1:0] {
    TURN_NONE  = 2'd0,
    TURN_RIGHT = 2'd1,
    TURN_LEFT  = 2'd2
  } turn_e;
endpackage

// File: rtl/key_turn_conditioner_key_debounce.sv
// Per-key conditioner: 2-flop synchroniser, debounce counter and debounced level.
//   clk, rst_n : clock, async active-low reset
//   key_n      : raw active-low key, asynchronous to clk
//   deb        : debounced level (1 = released)
//   press      : one-cycle pulse on the accepted released->pressed flip
module key_debounce #(
  parameter int DEBOUNCE_BITS = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic deb,
  output logic press
);
  logic                     s1_q, s1_d;
  logic                     s2_q, s2_d;
  logic                     deb_q, deb_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic                     cnt_full;

  assign cnt_full = (cnt_q == '1);

  always_comb begin
    s1_d  = key_n;
    s2_d  = s1_q;
    deb_d = deb_q;
    cnt_d = cnt_q;
    // Any sample agreeing with the accepted level restarts the hold count.
    if (s2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_full) begin
      deb_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      deb_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb   = deb_q;
  // Only the 1->0 flip is an event; releases are silent.
  assign press = ~s2_q & deb_q & cnt_full;
endmodule

// File: rtl/key_turn_conditioner.sv
// Conditions the right/left push-buttons into single pending turn requests
// for the game FSM. A debounced press loads a request that is held until the
// next game_tik consumes it.
//   clock_25    : 25 MHz system clock
//   reset       : async active-low reset
//   key_right_n : raw right button, active-low
//   key_left_n  : raw left button, active-low
//   game_tik    : one-cycle game step strobe, consumes the pending request
//   right_P     : pending right request (registered level)
//   left_P      : pending left request (registered level)
module key_turn_conditioner
  import key_turn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_BITS = DEBOUNCE_BITS_DEF
) (
  input  logic clock_25,
  input  logic reset,
  input  logic key_right_n,
  input  logic key_left_n,
  input  logic game_tik,
  output logic right_P,
  output logic left_P
);
  logic [NUM_KEYS-1:0] keys_n;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] key_deb_unused;
  turn_e               state_q, state_d;

  assign keys_n[KEY_RIGHT] = key_right_n;
  assign keys_n[KEY_LEFT]  = key_left_n;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_deb (
      .clk  (clock_25),
      .rst_n(reset),
      .key_n(keys_n[k]),
      .deb  (key_deb_unused[k]),
      .press(press[k])
    );
  end

  always_comb begin
    state_d = state_q;
    if (press[KEY_RIGHT] && press[KEY_LEFT]) begin
      state_d = TURN_NONE;           // conflicting presses cancel
    end else if (press[KEY_RIGHT]) begin
      state_d = TURN_RIGHT;          // last press wins, even over a pending one
    end else if (press[KEY_LEFT]) begin
      state_d = TURN_LEFT;
    end else if (game_tik) begin
      state_d = TURN_NONE;           // request consumed this step
    end
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) state_q <= TURN_NONE;
    else        state_q <= state_d;
  end

  // Encoding makes each output a single state flop bit.
  assign right_P = state_q[0];
  assign left_P  = state_q[1];
endmodule

// File: tb/tb_key_turn_conditioner.sv
module tb_key_turn_conditioner;
  localparam int DB  = 4;
  localparam int WIN = 1 << DB;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic kr = 1'b0, kl = 1'b0, tik = 1'b0;
  logic right_P, left_P;

  int errors = 0;
  int checks = 0;

  key_turn_conditioner #(.DEBOUNCE_BITS(DB)) dut (
    .clock_25   (clk),
    .reset      (reset),
    .key_right_n(kr),
    .key_left_n (kl),
    .game_tik   (tik),
    .right_P    (right_P),
    .left_P     (left_P)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic r; logic l; } exp_t;
  exp_t sb[$];

  // Reference model: raw key sample history per edge (index 0 = this edge).
  // The debounced level flips when the synchronised samples seen over the
  // last WIN cycles (raw samples 2..WIN+1 edges back) all disagree with it.
  logic hr[0:WIN+1];
  logic hl[0:WIN+1];
  logic deb_r = 1'b1, deb_l = 1'b1;
  int   st = 0;                       // 0 none, 1 right, 2 left
  logic allr, alll, pr, pl;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i <= WIN + 1; i++) begin hr[i] = 1'b1; hl[i] = 1'b1; end
      deb_r = 1'b1; deb_l = 1'b1; st = 0;
    end else begin
      for (int i = WIN + 1; i > 0; i--) begin hr[i] = hr[i-1]; hl[i] = hl[i-1]; end
      hr[0] = kr; hl[0] = kl;
      allr = 1'b1; alll = 1'b1;
      for (int i = 2; i <= WIN + 1; i++) begin
        if (hr[i] == deb_r) allr = 1'b0;
        if (hl[i] == deb_l) alll = 1'b0;
      end
      pr = allr && deb_r;
      pl = alll && deb_l;
      if (allr) deb_r = ~deb_r;
      if (alll) deb_l = ~deb_l;
      if (pr && pl)  st = 0;
      else if (pr)   st = 1;
      else if (pl)   st = 2;
      else if (tik)  st = 0;
    end
    sb.push_back('{r: (st == 1), l: (st == 2)});
  end

  // Monitor: outputs are levels, so every cycle presents a response.
  exp_t e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (!reset) begin
        if (right_P || left_P) begin
          errors++;
          $display("FAIL reset_outputs t=%0t got r=%0b l=%0b exp r=0 l=0", $time, right_P, left_P);
        end
      end else if (right_P !== e.r || left_P !== e.l) begin
        errors++;
        $display("FAIL outputs t=%0t got r=%0b l=%0b exp r=%0b l=%0b",
                 $time, right_P, left_P, e.r, e.l);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0b exp %0b", name, $time, got, exp);
    end
  endtask

  int len;

  initial begin
    // 1: reset with both keys held, then clean right press with latency check
    cyc(5);
    reset = 1'b1;
    cyc(100);
    kr = 1'b1; kl = 1'b1;
    cyc(30);
    kr = 1'b0;                        // next edge is edge 1
    cyc(17);
    chk("latency_edge17", right_P, 1'b0);
    cyc(1);
    chk("latency_edge18", right_P, 1'b1);
    cyc(10);
    // 3: consume, key still held -> no repeat
    tik = 1'b1;
    #1 chk("tik_cycle_right", right_P, 1'b1);
    cyc(1); tik = 1'b0;
    #1 chk("after_tik_right", right_P, 1'b0);
    repeat (3) begin cyc(6); tik = 1'b1; cyc(1); tik = 1'b0; end
    chk("no_autorepeat", right_P, 1'b0);
    // 2: bounce then stable low
    kr = 1'b1; cyc(30);
    for (int i = 0; i < 12; i++) begin kr = ~kr; cyc(5); end
    kr = 1'b0; cyc(30);
    tik = 1'b1; cyc(1); tik = 1'b0;
    // 4: override right by left
    kr = 1'b1; cyc(30);
    kr = 1'b0; cyc(40);
    kl = 1'b0; cyc(30);
    chk("override_left", left_P, 1'b1);
    tik = 1'b1; cyc(1); tik = 1'b0;
    chk("override_consumed", left_P, 1'b0);
    // 5: simultaneous presses cancel
    kr = 1'b1; kl = 1'b1; cyc(30);
    kr = 1'b0; kl = 1'b0; cyc(30);
    chk("simul_right", right_P, 1'b0);
    chk("simul_left", left_P, 1'b0);
    tik = 1'b1; cyc(1); tik = 1'b0;
    // 6: left press event lands in the tik cycle
    kr = 1'b1; kl = 1'b1; cyc(30);
    kr = 1'b0; cyc(30);
    kl = 1'b0; cyc(17);
    tik = 1'b1;
    #1 chk("collide_tik_right", right_P, 1'b1);
    cyc(1); tik = 1'b0;
    #1 chk("collide_left_loaded", left_P, 1'b1);
    cyc(20);
    tik = 1'b1; cyc(1); tik = 1'b0;
    chk("collide_left_consumed", left_P, 1'b0);
    // reset mid-debounce and with a request pending
    kr = 1'b1; kl = 1'b1; cyc(30);
    kr = 1'b0; cyc(8);
    reset = 1'b0; cyc(3); reset = 1'b1;
    cyc(30);
    reset = 1'b0; cyc(2); reset = 1'b1;
    cyc(5);
    // randomized segments with bounce and random tiks
    for (int s = 0; s < 150; s++) begin
      kr = 1'($urandom_range(0, 1));
      kl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        tik = ($urandom_range(0, 9) == 0);
        cyc(1);
      end
    end
    tik = 1'b0;
    cyc(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
